// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op codes, FSM states
// and the iteration counter width.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);

  // Counter width for an arbitrary operand width (same rule as MD_CNT_W).
  function automatic int md_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling around the unsigned iterator: absolute values
// of the operands going in, two's-complement correction of the result coming out.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic               is_signed_i,
  output logic [WIDTH-1:0]   abs1_o,
  output logic [WIDTH-1:0]   abs2_o,
  output logic               s1_o,
  output logic               s2_o,
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               is_mul_i,
  input  logic               neg_lo_i,
  input  logic               neg_hi_i,
  output logic [2*WIDTH-1:0] fixed_o
);

  assign s1_o   = is_signed_i & op1_i[WIDTH-1];
  assign s2_o   = is_signed_i & op2_i[WIDTH-1];
  assign abs1_o = s1_o ? (~op1_i + 1'b1) : op1_i;
  assign abs2_o = s2_o ? (~op2_i + 1'b1) : op2_i;

  // Products negate as one 2*WIDTH value; quotient and remainder negate independently.
  always_comb begin
    fixed_o = raw_i;
    if (is_mul_i) begin
      if (neg_lo_i) fixed_o = ~raw_i + 1'b1;
    end else begin
      if (neg_lo_i) fixed_o[WIDTH-1:0]       = ~raw_i[WIDTH-1:0] + 1'b1;
      if (neg_hi_i) fixed_o[2*WIDTH-1:WIDTH] = ~raw_i[2*WIDTH-1:WIDTH] + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle signed/unsigned multiply and divide for the EX stage, with
// start handshake, one-cycle ready pulse, stall request and flush annul.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o,
  output logic               stallreq_o
);

  localparam int CNT_W = md_cnt_width(WIDTH);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic               is_mul_q, neg_lo_q, neg_hi_q, dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic               op_valid, is_mul_op, is_signed_op, last_step, done_ok;
  logic [WIDTH-1:0]   abs1, abs2;
  logic               s1, s2;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] fast_prod;

  assign op_valid     = md_op_valid(op_i);
  assign is_mul_op    = (op_i == MD_MULT) || (op_i == MD_MULTU);
  assign is_signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign last_step    = (cnt_q == CNT_W'(WIDTH - 1));

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op1_i       (opdata1_i),
    .op2_i       (opdata2_i),
    .is_signed_i (is_signed_op),
    .abs1_o      (abs1),
    .abs2_o      (abs2),
    .s1_o        (s1),
    .s2_o        (s2),
    .raw_i       ({hi_q, lo_q}),
    .is_mul_i    (is_mul_q),
    .neg_lo_i    (neg_lo_q),
    .neg_hi_i    (neg_hi_q),
    .fixed_o     (fixed)
  );

  // Shift-add: hi accumulates, lo holds the multiplier and shifts product bits in.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  // Restoring divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;
  assign fast_prod = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, lo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && op_valid && !annul_i) begin
            cnt_q    <= '0;
            is_mul_q <= is_mul_op;
            dbz_q    <= 1'b0;
            if (is_mul_op) begin
              hi_q     <= '0;
              lo_q     <= abs2;
              b_q      <= abs1;
              neg_lo_q <= s1 ^ s2;
              neg_hi_q <= 1'b0;
              state_q  <= MUL;
            end else if (opdata2_i == '0) begin
              hi_q     <= opdata1_i;
              lo_q     <= '1;
              b_q      <= '0;
              neg_lo_q <= 1'b0;
              neg_hi_q <= 1'b0;
              dbz_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              hi_q     <= '0;
              lo_q     <= abs1;
              b_q      <= abs2;
              neg_lo_q <= s1 ^ s2;
              neg_hi_q <= s1;
              state_q  <= DIV;
            end
          end
        end
        MUL: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else if (FAST_MUL) begin
            {hi_q, lo_q} <= fast_prod;
            state_q      <= DONE;
          end else begin
            hi_q  <= mul_sum[WIDTH:1];
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) state_q <= DONE;
          end
        end
        DIV: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_q  <= {lo_q[WIDTH-2:0], div_ge};
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!annul_i) result_q <= fixed;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush landing in DONE suppresses the pulse and leaves result_o untouched.
  assign done_ok       = (state_q == DONE) && !annul_i;
  assign ready_o       = done_ok;
  assign result_o      = done_ok ? fixed : result_q;
  assign div_by_zero_o = done_ok & dbz_q;
  assign busy_o        = (state_q == MUL) || (state_q == DIV);
  assign stallreq_o    = ((state_q == IDLE) && start_i && op_valid) || busy_o;

endmodule
